// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
//   Execution-rate controller for the pipelined CPU. Produces a registered,
//   single-cycle step enable in one of four modes: slow run, fast run,
//   debounced push-button single-step, and halt. It also counts every step
//   pulse it issues, for the seven-segment display.
//
// Ports
//   clkIn        : the single clock; all state changes on its rising edge
//   resetIn      : synchronous, active-high reset
//   modeIn       : 00 slow run, 01 fast run, 10 single-step, 11 halt
//   stepBtnIn    : raw asynchronous push-button, high = pressed
//   cpuEnOut     : registered one-cycle CPU step enable
//   stepCountOut : number of cpuEnOut pulses since reset (wraps)
//   modeOut      : registered copy of the active mode
module cpu_clock_ctrl #(
  parameter int unsigned DIV_FAST_LOG2   = 23,
  parameter int unsigned DIV_SLOW_LOG2   = 25,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [1:0]  modeIn,
  input  logic        stepBtnIn,
  output logic        cpuEnOut,
  output logic [31:0] stepCountOut,
  output logic [1:0]  modeOut
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);
  localparam logic [DIV_SLOW_LOG2-1:0] DIV_ONE = DIV_SLOW_LOG2'(1);

  // The mode register doubles as the FSM state.
  typedef enum logic [1:0] {
    RUN_SLOW = 2'b00,
    RUN_FAST = 2'b01,
    STEP     = 2'b10,
    HALT     = 2'b11
  } mode_t;

  mode_t                    mode_reg;
  mode_t                    mode_next;
  logic [DIV_SLOW_LOG2-1:0] div_cnt;
  logic [DIV_SLOW_LOG2-1:0] div_next;
  logic                     tick;
  logic                     en_next;

  logic                     sync1;
  logic                     sync2;
  logic                     db_level;
  logic                     db_prev;
  logic [DB_W-1:0]          db_cnt;
  logic                     step_req;

  // ---------------------------------------------------------------------
  // State register: mode, divider and the registered step enable.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // ---------------------------------------------------------------------
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      mode_reg <= RUN_SLOW;
      div_cnt  <= '0;
      cpuEnOut <= 1'b0;
    end else begin
      mode_reg <= mode_next;
      div_cnt  <= div_next;
      cpuEnOut <= en_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output decode. The pulse is judged against the current
  // mode_reg, so a mode change landing on a tick or step request is decided
  // by the mode being left.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  // ---------------------------------------------------------------------
  always_comb begin
    mode_next = mode_t'(modeIn);
    div_next  = div_cnt + DIV_ONE;
    tick      = 1'b0;
    en_next   = 1'b0;

    // Any mode change restarts the period; the divider idles outside run.
    if ((mode_next != mode_reg) || (mode_reg == STEP) || (mode_reg == HALT)) begin
      div_next = '0;
    end

    unique case (mode_reg)
      RUN_SLOW: begin
        tick    = &div_cnt;
        en_next = tick;
      end
      RUN_FAST: begin
        tick    = &div_cnt[DIV_FAST_LOG2-1:0];
        en_next = tick;
      end
      STEP: begin
        // A request arriving in any other mode is simply dropped.
        en_next = step_req;
      end
      HALT: begin
        en_next = 1'b0;
      end
      default: begin
        en_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Button path: two-flop synchronizer, then a level debouncer that only
  // accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing
  // samples. It runs in every mode so a press is never half-counted across
  // a mode change.
  // ---------------------------------------------------------------------
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= stepBtnIn;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

  // Rising edge of the accepted level only; releases never request a step.
  assign step_req = db_level & ~db_prev;

  // ---------------------------------------------------------------------
  // Step counter: counts the pulse one cycle after it is issued.
  // ---------------------------------------------------------------------
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      stepCountOut <= 32'd0;
    end else if (cpuEnOut) begin
      stepCountOut <= stepCountOut + 32'd1;
    end
  end

  assign modeOut = mode_reg;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl with small parameters
// (fast period 4, slow period 16, debounce 4 cycles).
module tb_cpu_clock_ctrl;

  localparam int FAST = 2;
  localparam int SLOW = 4;
  localparam int DB   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        step_btn = 1'b0;
  logic        cpu_en;
  logic [31:0] step_count;
  logic [1:0]  mode_out;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(
    .DIV_FAST_LOG2  (FAST),
    .DIV_SLOW_LOG2  (SLOW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clkIn       (clk),
    .resetIn     (reset),
    .modeIn      (mode),
    .stepBtnIn   (step_btn),
    .cpuEnOut    (cpu_en),
    .stepCountOut(step_count),
    .modeOut     (mode_out)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int pulse_q[$];

  // Behavioural reference: pulses are derived from "edges since the mode was
  // loaded" and from a history window of synchronized button samples.
  logic [1:0]  m_mode  = 2'b00;
  int          m_age   = 0;
  logic        m_s1    = 1'b0;
  logic        m_s2    = 1'b0;
  logic        m_level = 1'b0;
  logic        m_rose  = 1'b0;
  logic        m_en    = 1'b0;
  logic [31:0] m_cnt   = 32'd0;
  logic        m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int get_pulse(input int i);
    if (i < pulse_q.size()) return pulse_q[i];
    return -1000;
  endfunction

  task automatic model_edge(input logic rst, input logic [1:0] md, input logic btn);
    logic en_new;
    logic rose_new;
    logic all_diff;
    if (rst) begin
      m_mode = 2'b00; m_age = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      m_level = 1'b0; m_rose = 1'b0; m_en = 1'b0; m_cnt = 32'd0;
      m_hist.delete();
      return;
    end
    en_new = 1'b0;
    if (m_mode == 2'b00 && ((m_age + 1) % (1 << SLOW)) == 0) en_new = 1'b1;
    if (m_mode == 2'b01 && ((m_age + 1) % (1 << FAST)) == 0) en_new = 1'b1;
    if (m_mode == 2'b10 && m_rose) en_new = 1'b1;
    if (m_en) m_cnt = m_cnt + 32'd1;
    // Accept the new level once the last DB synchronized samples since the
    // previous acceptance all disagree with the current level.
    rose_new = 1'b0;
    m_hist.push_back(m_s2);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    if (m_hist.size() == DB) begin
      all_diff = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        rose_new = m_level;
        m_hist.delete();
      end
    end
    m_rose = rose_new;
    m_s2 = m_s1;
    m_s1 = btn;
    m_age = (md != m_mode) ? 0 : m_age + 1;
    m_mode = md;
    m_en = en_new;
  endtask

  task automatic step_cycle(input logic rst, input logic [1:0] md, input logic btn);
    @(negedge clk);
    reset = rst; mode = md; step_btn = btn;
    model_edge(rst, md, btn);
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_en === 1'b1) pulse_q.push_back(cyc);
    check("model cpuEnOut", {31'd0, cpu_en}, {31'd0, m_en});
    check("model stepCountOut", step_count, m_cnt);
    check("model modeOut", {30'd0, mode_out}, {30'd0, m_mode});
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  md;
    logic        btn;
    int          cycles;
    int          exp_pulses;
    logic [31:0] exp_count;
    int          exp_first;
  } seg_t;

  seg_t segs[$];

  initial begin
    int e0;
    int nb;
    int s0;
    logic rbtn;
    int btn_left;

    // Directed segments for single-step, bounce and halt behaviour.
    segs.push_back('{1'b1, 2'd2, 1'b0,  2, 0, 32'd0, -1});
    segs.push_back('{1'b0, 2'd2, 1'b0,  4, 0, 32'd0, -1});
    segs.push_back('{1'b0, 2'd2, 1'b1, 12, 1, 32'd1,  6});
    segs.push_back('{1'b0, 2'd2, 1'b0, 12, 0, 32'd1, -1});
    segs.push_back('{1'b0, 2'd2, 1'b1, 12, 1, 32'd2,  6});
    segs.push_back('{1'b0, 2'd2, 1'b0, 12, 0, 32'd2, -1});
    for (int i = 0; i < 10; i++)
      segs.push_back('{1'b0, 2'd2, ((i % 2) == 0), 2, 0, 32'd2, -1});
    segs.push_back('{1'b0, 2'd2, 1'b0, 10, 0, 32'd2, -1});
    segs.push_back('{1'b0, 2'd3, 1'b1, 12, 0, 32'd2, -1});
    segs.push_back('{1'b0, 2'd3, 1'b0, 12, 0, 32'd2, -1});
    segs.push_back('{1'b0, 2'd3, 1'b1, 12, 0, 32'd2, -1});
    segs.push_back('{1'b0, 2'd3, 1'b0, 12, 0, 32'd2, -1});
    segs.push_back('{1'b0, 2'd3, 1'b0, 16, 0, 32'd2, -1});

    // Reset held with fast mode requested: everything reads zero.
    repeat (3) begin
      step_cycle(1'b1, 2'b01, 1'b0);
      check("reset cpuEnOut", {31'd0, cpu_en}, 32'd0);
      check("reset stepCountOut", step_count, 32'd0);
      check("reset modeOut", {30'd0, mode_out}, 32'd0);
    end

    // Fast run: mode loads on the first edge, pulses every 4 edges after it.
    nb = pulse_q.size();
    step_cycle(1'b0, 2'b01, 1'b0);
    e0 = cyc;
    check("fast modeOut after release", {30'd0, mode_out}, 32'd1);
    repeat (13) step_cycle(1'b0, 2'b01, 1'b0);
    check("fast pulse count", pulse_q.size() - nb, 3);
    check("fast pulse 1 offset", get_pulse(nb) - e0, 4);
    check("fast pulse 2 offset", get_pulse(nb + 1) - e0, 8);
    check("fast pulse 3 offset", get_pulse(nb + 2) - e0, 12);
    check("fast stepCountOut", step_count, 32'd3);

    // Switch to slow mid-period: period restarts from the switch.
    nb = pulse_q.size();
    step_cycle(1'b0, 2'b00, 1'b0);
    e0 = cyc;
    check("slow modeOut after switch", {30'd0, mode_out}, 32'd0);
    repeat (32) step_cycle(1'b0, 2'b00, 1'b0);
    check("slow pulse count", pulse_q.size() - nb, 2);
    check("slow pulse 1 offset", get_pulse(nb) - e0, 16);
    check("slow pulse 2 offset", get_pulse(nb + 1) - e0, 32);

    // Table of segments.
    foreach (segs[i]) begin
      nb = pulse_q.size();
      s0 = cyc + 1;
      for (int k = 0; k < segs[i].cycles; k++) step_cycle(segs[i].rst, segs[i].md, segs[i].btn);
      check($sformatf("seg %0d pulses", i), pulse_q.size() - nb, segs[i].exp_pulses);
      check($sformatf("seg %0d stepCountOut", i), step_count, segs[i].exp_count);
      if (segs[i].exp_first >= 0)
        check($sformatf("seg %0d first pulse offset", i), get_pulse(nb) - s0, segs[i].exp_first);
    end

    // Step request lands while the fast mode is active: dropped, not queued.
    nb = pulse_q.size();
    repeat (3) step_cycle(1'b0, 2'b11, 1'b1);
    repeat (3) step_cycle(1'b0, 2'b01, 1'b1);
    repeat (8) step_cycle(1'b0, 2'b10, 1'b1);
    repeat (12) step_cycle(1'b0, 2'b10, 1'b0);
    check("dropped request pulses", pulse_q.size() - nb, 0);
    check("dropped request stepCountOut", step_count, 32'd2);

    // Reset three cycles into a press; button held through reset.
    repeat (3) step_cycle(1'b0, 2'b10, 1'b1);
    repeat (3) begin
      step_cycle(1'b1, 2'b10, 1'b1);
      check("mid-press reset cpuEnOut", {31'd0, cpu_en}, 32'd0);
      check("mid-press reset stepCountOut", step_count, 32'd0);
      check("mid-press reset modeOut", {30'd0, mode_out}, 32'd0);
    end
    nb = pulse_q.size();
    s0 = cyc + 1;
    repeat (14) step_cycle(1'b0, 2'b10, 1'b1);
    repeat (12) step_cycle(1'b0, 2'b10, 1'b0);
    check("post-reset pulses", pulse_q.size() - nb, 1);
    check("post-reset pulse offset", get_pulse(nb) - s0, 6);
    check("post-reset stepCountOut", step_count, 32'd1);

    // Randomized modes, button activity and occasional reset vs. the model.
    rbtn = 1'b0;
    btn_left = 0;
    for (int blk = 0; blk < 60; blk++) begin
      logic [1:0] md;
      int hold;
      md = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 40);
      for (int k = 0; k < hold; k++) begin
        if (btn_left == 0) begin
          rbtn = ~rbtn;
          btn_left = $urandom_range(1, 8);
        end
        btn_left--;
        step_cycle(($urandom_range(0, 199) == 0), md, rbtn);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Execution-rate controller for the pipelined CPU top level. It sits upstream of the PC and every pipeline register, and produces the single-cycle enable `cpuEnOut` that gates each CPU step. It replaces the raw `clkdiv` tap with four modes: slow run, fast run, debounced single-step from a push-button, and halt. It also keeps a step counter for the seven-segment display path.

## Interface
Parameters:
- `DIV_FAST_LOG2`, 23, log2 of the fast-run period in `clkIn` cycles; must satisfy 1 ≤ `DIV_FAST_LOG2` < `DIV_SLOW_LOG2`.
- `DIV_SLOW_LOG2`, 25, log2 of the slow-run period in `clkIn` cycles; must be ≤ 31.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required before the button level is accepted; must be ≥ 2.

Ports:
- `clkIn` in 1: the single clock; all state updates on its rising edge.
- `resetIn` in 1: reset, synchronous, active-high.
- `modeIn` in 2: 00 slow run, 01 fast run, 10 single-step, 11 halt.
- `stepBtnIn` in 1: raw, asynchronous, bouncing push-button; high = pressed.
- `cpuEnOut` out 1: registered one-cycle CPU step enable.
- `stepCountOut` out 32: number of `cpuEnOut` pulses issued since reset.
- `modeOut` out 2: registered copy of the active mode.

## Operation
- **Mode register.** `modeReg` samples `modeIn` every cycle. All behaviour below uses `modeReg`, so a mode change takes effect one cycle after it is sampled. `modeOut` = `modeReg`.
- **Divider.** `divCnt` is `DIV_SLOW_LOG2` bits wide.
  - Next value is 0 when `modeIn != modeReg`, or when `modeReg` is 10 or 11.
  - Otherwise it increments, wrapping at 2^`DIV_SLOW_LOG2`.
  - `tick` asserts when the low `DIV_FAST_LOG2` bits of `divCnt` are all ones (mode 01), or when all `DIV_SLOW_LOG2` bits are all ones (mode 00).
- **Button path.**
  - Two-flop synchronizer: `sync1` then `sync2`.
  - Debounce counter `dbCnt`, 0 .. `DEBOUNCE_CYCLES`-1:
    - if `sync2 == dbLevel`, `dbCnt` ← 0;
    - else if `dbCnt == DEBOUNCE_CYCLES-1`, `dbLevel` toggles and `dbCnt` ← 0;
    - else `dbCnt` increments.
  - `dbPrev` ← `dbLevel`; `stepReq` = `dbLevel & ~dbPrev`.
- **Output.** `cpuEnOut` ← (`modeReg` ∈ {00,01} & `tick`) | (`modeReg` == 10 & `stepReq`).
  - `stepReq` outside mode 10 is discarded, never queued.
  - In mode 11, `cpuEnOut` stays 0.
- **Counter.** `stepCountOut` increments on every edge where `cpuEnOut` is 1, so it reflects a pulse one cycle after that pulse. It wraps from 0xFFFFFFFF to 0.
- **FSM view** (encoded by `modeReg`): RUN_SLOW, RUN_FAST, STEP, HALT.
  - Any state → any state on a `modeIn` change.
  - Every transition clears `divCnt`.
  - The debouncer keeps running across all transitions.

## Timing
- **Reset.** `cpuEnOut`=0, `stepCountOut`=0, `modeOut`=00. Internal `divCnt`, `dbCnt`, `dbLevel`, `dbPrev`, `sync1`, `sync2` are all 0.
- **Reset priority.** Reset has priority over all updates. Reset asserted mid-debounce or mid-period discards the partial count; no pulse is produced from pre-reset state.
- **Button held through reset.** It is debounced afresh after reset and yields exactly one step in mode 10.
- **Run-mode latency.** If edge e0 loads a new run mode into `modeReg`, the first `cpuEnOut` is high after edge e0+2^N, then every 2^N cycles (N = `DIV_FAST_LOG2` or `DIV_SLOW_LOG2`).
- **Pulse width.** `cpuEnOut` is never high on two consecutive cycles.
- **Step latency.** If edge b0 first samples `stepBtnIn`=1 and the button stays high, `cpuEnOut` is high after edge b0+`DEBOUNCE_CYCLES`+2, for exactly one cycle.
- **Release.** Release is debounced identically and produces no pulse.
- **Bounce rejection.** Any `sync2` excursion shorter than `DEBOUNCE_CYCLES` cycles is rejected.
- **Mode change coincident with a tick or `stepReq`.** The pulse is decided by the old `modeReg` value, since `modeReg` updates on the same edge as `cpuEnOut`.

## Test plan
Parameters for all scenarios: `DIV_FAST_LOG2`=2, `DIV_SLOW_LOG2`=4, `DEBOUNCE_CYCLES`=4.
1. **Reset.** Hold reset 3 cycles with `modeIn`=01 → all outputs 0. Release reset → `modeOut`=01 after the first edge, pulses at 4-cycle intervals, first pulse 4 cycles after that edge. After 3 pulses, `stepCountOut`=3.
2. **Mode switch.** Switch 01→00 mid-period → no pulse until 16 cycles after `modeOut` becomes 00, then a 16-cycle period.
3. **Single step.** Mode 10, button high 12 cycles → exactly one pulse, 6 cycles after first sample. Release 12 cycles, press again → second pulse; `stepCountOut`=2.
4. **Bounce.** Mode 10, button toggling every 2 cycles for 20 cycles, then low → zero pulses, `stepCountOut` unchanged.
5. **Halt and mode-leave.** Mode 11, 64 cycles with two full presses → no pulses. Press during 01→10 transition timed so `stepReq` falls in mode 01 → no pulse.
6. **Reset mid-debounce.** Assert `resetIn` 3 cycles into a press → no pulse; outputs reset to 0; debounce restarts and gives one pulse 6 cycles after reset release.
